// File: rtl/xbar_ser_pkg.sv
// Shared definitions for the crossbar result serializer: geometry constants,
// the reduced-word type and the count-reduction helpers.
// Optional feature macro: XBAR_SER_SATURATE_EN. When it is defined, counts are
// clamped to the 3-bit range. When it is undefined, counts are truncated.
package xbar_ser_pkg;

    localparam int COLS  = 4;
    localparam int RBITS = 3;
    localparam int CBITS = 4;
    localparam int WBITS = COLS * RBITS;
    localparam logic [1:0] PHASE_LAST = 2'd2;

    // One queued word: reduced positive and negative column counts.
    // Column k occupies bits [3k+2:3k] of each half.
    typedef struct packed {
        logic [WBITS-1:0] pos;
        logic [WBITS-1:0] neg;
    } xbar_word_t;

    function automatic logic [RBITS-1:0] reduce_count(input logic [CBITS-1:0] count);
`ifdef XBAR_SER_SATURATE_EN
        reduce_count = (|count[CBITS-1:RBITS]) ? '1 : count[RBITS-1:0];
`else
        reduce_count = count[RBITS-1:0];
`endif
    endfunction

    // Reduce every column of a packed count bus.
    function automatic logic [WBITS-1:0] reduce_bus(input logic [COLS*CBITS-1:0] counts);
        reduce_bus = '0;
        for (int k = 0; k < COLS; k++) begin
            reduce_bus[RBITS*k +: RBITS] = reduce_count(counts[CBITS*k +: CBITS]);
        end
    endfunction

    // Pick bit 'ph' from each column; lane k carries column k.
    function automatic logic [COLS-1:0] lane_bits(input logic [WBITS-1:0] word,
                                                  input logic [1:0] ph);
        lane_bits = '0;
        for (int k = 0; k < COLS; k++) begin
            lane_bits[k] = word[RBITS*k + int'(ph)];
        end
    endfunction

endpackage

// File: rtl/xbar_result_serializer_if.sv
// Load handshake and serial result bus of the crossbar result serializer.
// The master side is the upstream producer and the downstream receiver.
// The slave side is the serializer.
interface xbar_result_serializer_if;
    import xbar_ser_pkg::*;

    logic                    load_valid;
    logic                    load_ready;
    logic [COLS*CBITS-1:0]   load_pos;
    logic [COLS*CBITS-1:0]   load_neg;
    logic [COLS-1:0]         posxbarsig_result_c;
    logic [COLS-1:0]         negxbarsig_result_c;
    logic                    frame_valid;
    logic                    frame_last;
    logic [1:0]              phase;

    modport master (
        output load_valid, load_pos, load_neg,
        input  load_ready, posxbarsig_result_c, negxbarsig_result_c,
               frame_valid, frame_last, phase
    );

    modport slave (
        input  load_valid, load_pos, load_neg,
        output load_ready, posxbarsig_result_c, negxbarsig_result_c,
               frame_valid, frame_last, phase
    );

endinterface

// File: rtl/xbar_ser_fifo.sv
// Two-entry synchronous FIFO of reduced words.
// Reset flushes the FIFO by clearing its pointers and occupancy.
// A push while full and a pop while empty are ignored.
module xbar_ser_fifo
    import xbar_ser_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       push,
    input  xbar_word_t push_data,
    input  logic       pop,
    output xbar_word_t pop_data,
    output logic       full,
    output logic       empty
);

    xbar_word_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Write storage on push.
    // NOTE: the storage array is deliberately not reset; the cleared occupancy
    // count guarantees that stale entries are never read.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Advance the pointers and the occupancy; reset empties the FIFO.
    // NOTE: state is updated with non-blocking assignments, so every register
    // samples the values that existed before the edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= !wr_ptr;
            if (do_pop)  rd_ptr <= !rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/xbar_result_serializer.sv
// Transmit-side serializer for the crossbar compute-result bus.
// Each accepted word holds four positive and four negative 4-bit column counts.
// The word is reduced to 3 bits per column, queued in a 2-entry FIFO, and
// streamed LSB first over 3-cycle frames. Frames are aligned to a free-running
// phase counter that runs 0,1,2. A word can only start at a phase-2 edge.
// Optional feature macro: XBAR_SER_SATURATE_EN (see xbar_ser_pkg).
module xbar_result_serializer
    import xbar_ser_pkg::*;
(
    input logic                      CLK,
    input logic                      RESET,
    xbar_result_serializer_if.slave  bus
);

    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            frame_end;
    xbar_word_t      push_word;
    xbar_word_t      head_word;

    logic [1:0]      phase_q,       phase_d;
    logic            frame_valid_q, frame_valid_d;
    xbar_word_t      word_q,        word_d;
    logic [COLS-1:0] pos_bits_q,    pos_bits_d;
    logic [COLS-1:0] neg_bits_q,    neg_bits_d;

    assign frame_end     = (phase_q == PHASE_LAST);
    assign bus.load_ready = !fifo_full && !RESET;
    assign push          = bus.load_valid && bus.load_ready;
    assign pop           = frame_end && !fifo_empty;
    assign push_word     = '{pos: reduce_bus(bus.load_pos), neg: reduce_bus(bus.load_neg)};

    xbar_ser_fifo u_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next phase, frame start/stop, and the serial bits for the next cycle.
    // NOTE: every output of this block gets a default value first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        phase_d       = frame_end ? 2'd0 : phase_q + 2'd1;
        frame_valid_d = frame_valid_q;
        word_d        = word_q;
        pos_bits_d    = '0;
        neg_bits_d    = '0;
        if (frame_end) begin
            frame_valid_d = pop;
            word_d        = pop ? head_word : '0;
        end
        if (frame_valid_d) begin
            pos_bits_d = lane_bits(word_d.pos, phase_d);
            neg_bits_d = lane_bits(word_d.neg, phase_d);
        end
    end

    // Output and frame registers; reset aborts any frame and restarts the phase.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            phase_q       <= 2'd0;
            frame_valid_q <= 1'b0;
            word_q        <= '0;
            pos_bits_q    <= '0;
            neg_bits_q    <= '0;
        end else begin
            phase_q       <= phase_d;
            frame_valid_q <= frame_valid_d;
            word_q        <= word_d;
            pos_bits_q    <= pos_bits_d;
            neg_bits_q    <= neg_bits_d;
        end
    end

    assign bus.phase               = phase_q;
    assign bus.frame_valid         = frame_valid_q;
    assign bus.frame_last          = frame_valid_q && frame_end;
    assign bus.posxbarsig_result_c = pos_bits_q;
    assign bus.negxbarsig_result_c = neg_bits_q;

endmodule

// File: tb/tb_xbar_result_serializer.sv
// Directed bench for xbar_result_serializer. Each record describes one clock
// cycle. It gives the inputs driven before the edge, the load_ready expected
// before the edge, and the registered outputs expected after the edge.
module tb_xbar_result_serializer;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    always #5 CLK = ~CLK;

    xbar_result_serializer_if bus ();

    xbar_result_serializer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic [15:0] pos;
        logic [15:0] neg;
        logic        ready;
        logic [1:0]  ph;
        logic        fv;
        logic [3:0]  pb;
        logic [3:0]  nb;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [15:0] actual,
                         input logic [15:0] expected);
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic valid,
                                input logic [15:0] pos, input logic [15:0] neg,
                                input logic ready, input logic [1:0] ph,
                                input logic fv, input logic [3:0] pb,
                                input logic [3:0] nb);
        vec_t v;
        v.rst = rst; v.valid = valid; v.pos = pos; v.neg = neg;
        v.ready = ready; v.ph = ph; v.fv = fv; v.pb = pb; v.nb = nb;
        return v;
    endfunction

    function automatic void idle(input logic ready, input logic [1:0] ph);
        vecs.push_back(mk(1'b0, 1'b0, 16'h0, 16'h0, ready, ph, 1'b0, 4'h0, 4'h0));
    endfunction

    function automatic void load(input logic [15:0] pos, input logic [15:0] neg,
                                 input logic ready, input logic [1:0] ph,
                                 input logic fv, input logic [3:0] pb,
                                 input logic [3:0] nb);
        vecs.push_back(mk(1'b0, 1'b1, pos, neg, ready, ph, fv, pb, nb));
    endfunction

    function automatic void bits(input logic ready, input logic [1:0] ph,
                                 input logic [3:0] pb, input logic [3:0] nb);
        vecs.push_back(mk(1'b0, 1'b0, 16'h0, 16'h0, ready, ph, 1'b1, pb, nb));
    endfunction

    task automatic apply(input vec_t v, input string tag);
        @(negedge CLK);
        RESET          = v.rst;
        bus.load_valid = v.valid;
        bus.load_pos   = v.pos;
        bus.load_neg   = v.neg;
        #1;
        check({tag, ".load_ready"}, 16'(bus.load_ready), 16'(v.ready));
        @(posedge CLK);
        #1;
        check({tag, ".phase"},       16'(bus.phase),       16'(v.ph));
        check({tag, ".frame_valid"}, 16'(bus.frame_valid), 16'(v.fv));
        check({tag, ".frame_last"},  16'(bus.frame_last),
              16'(v.fv && (v.ph == 2'd2)));
        check({tag, ".pos_bus"},     16'(bus.posxbarsig_result_c), 16'(v.pb));
        check({tag, ".neg_bus"},     16'(bus.negxbarsig_result_c), 16'(v.nb));
        n_vec++;
    endtask

    initial begin
        logic [3:0] sat1;
        logic [3:0] sat2;
        bus.load_valid = 1'b0;
        bus.load_pos   = 16'h0;
        bus.load_neg   = 16'h0;

        // Reset held for two cycles, then nine idle cycles.
        vecs.push_back(mk(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0));
        for (int i = 0; i < 9; i++) idle(1'b1, 2'((i + 1) % 3));

        // Load the columns 5,3,7,0 while phase is 1. The frame starts one cycle later.
        idle(1'b1, 2'd1);
        load(16'h0735, 16'h0000, 1'b1, 2'd2, 1'b0, 4'h0, 4'h0);
        bits(1'b1, 2'd0, 4'b0111, 4'b0000);
        bits(1'b1, 2'd1, 4'b0110, 4'b0000);
        bits(1'b1, 2'd2, 4'b0101, 4'b0000);
        idle(1'b1, 2'd0);

        // Three words back to back: A, then B, then C, which stalls until A pops.
        load(16'h1234, 16'h0765, 1'b1, 2'd1, 1'b0, 4'h0, 4'h0);       // A accepted
        load(16'h0006, 16'h7000, 1'b1, 2'd2, 1'b0, 4'h0, 4'h0);       // B accepted
        load(16'h0735, 16'h0012, 1'b0, 2'd0, 1'b1, 4'b1010, 4'b0101); // C stalled
        load(16'h0735, 16'h0012, 1'b1, 2'd1, 1'b1, 4'b0110, 4'b0110); // C accepted
        bits(1'b0, 2'd2, 4'b0001, 4'b0111);
        bits(1'b0, 2'd0, 4'b0000, 4'b1000);
        bits(1'b1, 2'd1, 4'b0001, 4'b1000);
        bits(1'b1, 2'd2, 4'b0001, 4'b1000);
        bits(1'b1, 2'd0, 4'b0111, 4'b0010);
        bits(1'b1, 2'd1, 4'b0110, 4'b0001);
        bits(1'b1, 2'd2, 4'b0101, 4'b0000);
        idle(1'b1, 2'd0);

        // Column 0 carries the count 9. It saturates to 7 or truncates to 1.
`ifdef XBAR_SER_SATURATE_EN
        sat1 = 4'b0001; sat2 = 4'b0001;
`else
        sat1 = 4'b0000; sat2 = 4'b0000;
`endif
        load(16'h0009, 16'h0000, 1'b1, 2'd1, 1'b0, 4'h0, 4'h0);
        idle(1'b1, 2'd2);
        bits(1'b1, 2'd0, 4'b0001, 4'b0000);
        bits(1'b1, 2'd1, sat1, 4'b0000);
        bits(1'b1, 2'd2, sat2, 4'b0000);
        idle(1'b1, 2'd0);

        // A load at phase 2 waits through one idle frame, so bit 0 appears 3 cycles later.
        idle(1'b1, 2'd1);
        idle(1'b1, 2'd2);
        load(16'h0123, 16'h3210, 1'b1, 2'd0, 1'b0, 4'h0, 4'h0);
        idle(1'b1, 2'd1);
        idle(1'b1, 2'd2);
        bits(1'b1, 2'd0, 4'b0101, 4'b1010);
        bits(1'b1, 2'd1, 4'b0011, 4'b1100);
        bits(1'b1, 2'd2, 4'b0000, 4'b0000);
        idle(1'b1, 2'd0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

        // Reset asserted in phase 1 of an active frame while word F is queued.
        apply(mk(1'b0, 1'b1, 16'h0003, 16'h0000, 1'b1, 2'd1, 1'b0, 4'h0, 4'h0), "rst.push_e");
        apply(mk(1'b0, 1'b1, 16'h7777, 16'h7777, 1'b1, 2'd2, 1'b0, 4'h0, 4'h0), "rst.push_f");
        apply(mk(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0, 1'b1, 4'b0001, 4'b0000), "rst.e_bit0");
        apply(mk(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 2'd1, 1'b1, 4'b0001, 4'b0000), "rst.e_bit1");
        apply(mk(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0), "rst.abort");
        for (int i = 0; i < 7; i++) begin
            apply(mk(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 2'((i + 1) % 3), 1'b0, 4'h0, 4'h0),
                  $sformatf("rst.after%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
